// File: rtl/rfphoenix_pkg.sv
// Shared constants and types for the rfphoenix FIFO pop-side logic.
package rfphoenix_pkg;

   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_CNT_W = 4;
   localparam int SKID_DEPTH = 2;
   localparam int WORD_W     = 3;

   typedef logic [WORD_W-1:0] fifo_word_t;
   typedef logic [1:0]        skid_occ_t;

endpackage

// File: rtl/rfphoenix_skid2.sv
// Two-entry FIFO-ordered skid buffer: pop shifts the head out, then push lands at the new tail.
module rfphoenix_skid2
   import rfphoenix_pkg::*;
#(
   parameter int WID = WORD_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           push,
   input  logic [WID-1:0] push_data,
   input  logic           pop,
   output skid_occ_t      occ,
   output logic [WID-1:0] head
);

   logic [WID-1:0] entry [SKID_DEPTH];
   skid_occ_t      occ_after_pop;

   assign occ_after_pop = occ - skid_occ_t'(pop);
   assign head          = entry[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ <= '0;
         // NOTE: the entries are reset too, because the head word is visible on out_data straight out of reset.
         entry[0] <= '0;
         entry[1] <= '0;
      end else if (flush) begin
         occ <= '0;
      end else begin
         if (pop)
            entry[0] <= entry[1];
         // A push after a pop targets the slot freed by the shift, so it overrides the shift above.
         if (push)
            entry[occ_after_pop[0]] <= push_data;
         occ <= occ_after_pop + skid_occ_t'(push);
      end
   end

endmodule

// File: rtl/rfphoenix_fifo_reader.sv
// Pop-side controller for the 16-entry registered-output FIFO: pop credit, read-latency
// tracking, valid/ready presentation through a skid buffer, delivered-word counter.
module rfphoenix_fifo_reader
   import rfphoenix_pkg::*;
#(
   parameter int WID = 3,
   parameter int CW  = 16
) (
   input  logic                  rst_n,
   input  logic                  clk,
   input  logic                  en,
   input  logic                  flush,
   input  logic [FIFO_CNT_W-1:0] fifo_cnt,
   input  logic                  fifo_wr,
   input  logic [WID-1:0]        fifo_dout,
   output logic                  fifo_rd,
   output logic                  out_valid,
   output logic [WID-1:0]        out_data,
   input  logic                  out_ready,
   output logic [CW-1:0]         pop_count,
   output logic                  drained
);

   skid_occ_t  occ;
   logic       inflight;
   logic       deq;
   logic [2:0] committed;

   assign out_valid = (occ != '0);
   assign deq       = out_valid & out_ready;

   // Words already owed to the skid buffer after this cycle's dequeue; 3 bits so the
   // subtraction cannot wrap when the buffer is empty.
   assign committed = 3'(occ) + 3'(inflight) - 3'(deq);

   // Writer wins a same-cycle collision, since rd+wr together is a FIFO no-op.
   assign fifo_rd = rst_n & en & ~flush & (fifo_cnt != '0) & ~fifo_wr
                  & (committed < 3'(SKID_DEPTH));

   assign drained = (fifo_cnt == '0) & ~inflight & (occ == '0);

   rfphoenix_skid2 #(.WID(WID)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (inflight),
      .push_data (fifo_dout),
      .pop       (deq),
      .occ       (occ),
      .head      (out_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight  <= 1'b0;
         pop_count <= '0;
      end else begin
         // fifo_rd is already forced low during flush, so this also clears inflight on flush.
         inflight <= fifo_rd;
         if (deq)
            pop_count <= pop_count + CW'(1);
      end
   end

endmodule

// File: tb/tb_rfphoenix_fifo_reader.sv
// Self-checking bench: behavioural FIFO plus a scoreboard of popped-but-undelivered words.
module tb_rfphoenix_fifo_reader;

   localparam int WID = 3;
   localparam int CW  = 16;

   typedef struct {
      logic [WID-1:0] data;
      int             pop_cyc;
   } pend_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           en = 1'b0;
   logic           flush = 1'b0;
   logic [3:0]     fifo_cnt = '0;
   logic           fifo_wr = 1'b0;
   logic [WID-1:0] fifo_din = '0;
   logic [WID-1:0] fifo_dout = '0;
   logic           fifo_rd;
   logic           out_valid;
   logic [WID-1:0] out_data;
   logic           out_ready = 1'b0;
   logic [CW-1:0]  pop_count;
   logic           drained;

   logic [WID-1:0] fifo_q [$];
   pend_t          pend [$];
   logic [CW-1:0]  exp_count = '0;
   int             cyc = 0;
   bit             refill = 1'b0;
   int             n_checks = 0;
   int             n_pass = 0;

   rfphoenix_fifo_reader #(.WID(WID), .CW(CW)) dut (
      .rst_n     (rst_n),
      .clk       (clk),
      .en        (en),
      .flush     (flush),
      .fifo_cnt  (fifo_cnt),
      .fifo_wr   (fifo_wr),
      .fifo_dout (fifo_dout),
      .fifo_rd   (fifo_rd),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .pop_count (pop_count),
      .drained   (drained)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Behavioural FIFO: registered read data, occupancy counted after the pop/push.
   always @(posedge clk) begin
      if (fifo_rd && !fifo_wr && fifo_q.size() > 0)
         fifo_dout <= fifo_q.pop_front();
      else if (fifo_wr && !fifo_rd)
         fifo_q.push_back(fifo_din);
      if (refill)
         while (fifo_q.size() < 16) fifo_q.push_back(WID'($urandom));
      fifo_cnt <= (fifo_q.size() > 15) ? 4'd15 : 4'(fifo_q.size());
   end

   // Scoreboard: sampled just before each rising edge, while all inputs are stable.
   always @(negedge clk) begin
      #4;
      cyc++;
      if (rst_n) begin
         bit             exp_valid;
         bit             exp_deq;
         bit             exp_rd;
         logic [WID-1:0] head;
         exp_valid = (pend.size() > 0) && (pend[0].pop_cyc + 2 <= cyc);
         head      = exp_valid ? pend[0].data : '0;
         exp_deq   = exp_valid && out_ready;
         exp_rd    = en && !flush && (fifo_cnt != 0) && !fifo_wr
                     && ((pend.size() - int'(exp_deq)) < 2);
         check("out_valid", 32'(out_valid), 32'(exp_valid));
         if (exp_valid) check("out_data", 32'(out_data), 32'(head));
         check("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
         check("drained", 32'(drained), 32'((fifo_cnt == 0) && (pend.size() == 0)));
         check("pop_count", 32'(pop_count), 32'(exp_count));
         if (exp_deq) begin
            void'(pend.pop_front());
            exp_count++;
         end
         if (flush) pend.delete();
         if (exp_rd && fifo_q.size() > 0) pend.push_back('{data: fifo_q[0], pop_cyc: cyc});
      end
   end

   task automatic preload(input int n, input logic [31:0] words);
      for (int i = 0; i < n; i++) fifo_q.push_back(WID'(words >> (4 * i)));
   endtask

   task automatic wait_drained(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         #1;
         seen = drained;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      logic [15:0]    start;
      logic [WID-1:0] nxt;
      int             rd_mask;
      int             vld_mask;
      int             k;
      bit             seen;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Stream 5,1,7,2,4 at full rate.
      preload(5, 32'h0004_2715);
      @(negedge clk);
      en = 1'b1;
      out_ready = 1'b1;
      rd_mask = 0;
      vld_mask = 0;
      k = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         rd_mask  |= int'(fifo_rd) << i;
         vld_mask |= int'(out_valid) << i;
         if (out_valid && k < 5) begin
            check("stream_data", 32'(out_data), 32'((32'h0004_2715 >> (4 * k)) & 7));
            k++;
         end
         @(negedge clk);
      end
      check("stream_rd_mask", 32'(rd_mask), 32'h01f);
      check("stream_valid_mask", 32'(vld_mask), 32'h07c);
      check("stream_count", 32'(pop_count), 32'd5);
      #1 check("stream_drained", 32'(drained), 32'd1);

      // Backpressure: only two pops while the consumer stalls, head holds.
      en = 1'b0;
      out_ready = 1'b0;
      preload(4, 32'h0000_1635);
      @(negedge clk);
      start = pop_count;
      en = 1'b1;
      k = 0;
      for (int i = 0; i < 8; i++) begin
         #1 k += int'(fifo_rd);
         @(negedge clk);
      end
      #1;
      check("bp_pulses", 32'(k), 32'd2);
      check("bp_head", 32'(out_data), 32'd5);
      out_ready = 1'b1;
      wait_drained("bp_drain_timeout");
      check("bp_count", 32'(pop_count - start), 32'd4);

      // Writer priority: the write cycle blocks the pop, the next cycle pops.
      @(negedge clk);
      en = 1'b0;
      preload(3, 32'h0000_0246);
      @(negedge clk);
      start = pop_count;
      en = 1'b1;
      fifo_wr = 1'b1;
      fifo_din = 3'd3;
      #1 check("wr_blocks_rd", 32'(fifo_rd), 32'd0);
      @(negedge clk);
      fifo_wr = 1'b0;
      #1 check("rd_after_wr", 32'(fifo_rd), 32'd1);
      wait_drained("wr_drain_timeout");
      check("wr_count", 32'(pop_count - start), 32'd4);

      // Flush while streaming: in-flight and buffered words dropped.
      preload(8, 32'h3456_7012);
      repeat (5) @(negedge clk);
      flush = 1'b1;
      nxt = fifo_q[0];
      #1 check("flush_rd", 32'(fifo_rd), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1 check("flush_valid", 32'(out_valid), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         #1 seen = out_valid;
      end
      check("flush_resume_timeout", 32'(seen), 32'd1);
      check("flush_next_word", 32'(out_data), 32'(nxt));
      wait_drained("flush_drain_timeout");

      // Reset mid-stream with a full skid buffer.
      out_ready = 1'b0;
      preload(4, 32'h0000_5274);
      repeat (5) @(negedge clk);
      check("pre_reset_full", 32'(pend.size()), 32'd2);
      rst_n = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_rd", 32'(fifo_rd), 32'd0);
      check("rst_count", 32'(pop_count), 32'd0);
      pend.delete();
      fifo_q.delete();
      exp_count = '0;
      @(negedge clk);
      #1 check("rst_drained", 32'(drained), 32'd1);
      rst_n = 1'b1;

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         en        = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         flush     = ($urandom_range(39) == 0);
         fifo_wr   = (fifo_q.size() < 14) && ($urandom_range(2) == 0);
         fifo_din  = WID'($urandom);
      end
      @(negedge clk);
      flush = 1'b0;
      fifo_wr = 1'b0;
      en = 1'b1;
      out_ready = 1'b1;
      wait_drained("rand_drain_timeout");

      // Counter wrap: stream until 0xFFFF delivered, then one more word.
      refill = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 70000 && !seen; i++) begin
         @(negedge clk);
         seen = (exp_count == 16'hFFFF);
      end
      out_ready = 1'b0;
      check("wrap_reach_timeout", 32'(seen), 32'd1);
      #1 check("wrap_pre", 32'(pop_count), 32'h0000_FFFF);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1 check("wrap_post", 32'(pop_count), 32'd0);

      refill = 1'b0;
      en = 1'b0;
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
